barrel_shift_sched: RTL and testbench

- Round-robin scheduler that shares one external BarrelShifter (WIDTH-bit, logical, zero-fill) among NUM_REQ requesters.
- Per requester: valid/ready handshake in. Single registered response channel out, with requester ID.
- Drives the shifter's data_in/shift_amount/shift_left from its own operand registers and samples data_out; contains no shift logic itself.

---
 rtl/barrel_shift_sched_pkg.sv | 16 +
 rtl/barrel_shift_sched_rr_arbiter.sv | 42 ++++
 rtl/barrel_shift_sched.sv | 198 +++++++++++++++++++
 tb/tb_barrel_shift_sched.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shift_sched_pkg.sv
// Shared types for the barrel shifter scheduler.
// Optional feature macro: BARREL_SHIFT_SCHED_ROTATE_EN (adds the SHIFT2 pass).
package barrel_shift_sched_pkg;

   localparam int DEFAULT_WIDTH   = 8;
   localparam int DEFAULT_NUM_REQ = 4;

   // SHIFT2 is only reachable when rotate support is compiled in.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      SHIFT2 = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/barrel_shift_sched_rr_arbiter.sv
// Combinational round-robin priority arbiter: first requester at or
// after ptr (with wrap) wins. Grant is one-hot or zero.
module rr_arbiter
   import barrel_shift_sched_pkg::*;
#(
   parameter int NUM_REQ = DEFAULT_NUM_REQ,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx
);

   localparam logic [ID_W:0] NUM_REQ_V = (ID_W+1)'(NUM_REQ);

   logic [ID_W:0]   sum;
   logic [ID_W-1:0] idx;
   logic            found;

   // Walk from ptr upward, wrapping once, and stop at the first active request.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         sum = {1'b0, ptr} + (ID_W+1)'(off);
         if (sum >= NUM_REQ_V) begin
            sum = sum - NUM_REQ_V;
         end
         idx = sum[ID_W-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/barrel_shift_sched.sv
// Round-robin scheduler sharing one external combinational barrel shifter
// among NUM_REQ requesters; one registered response channel with requester ID.
// Optional feature macro: BARREL_SHIFT_SCHED_ROTATE_EN (two-pass rotate).
//
// Handshakes: a request transfers in a cycle where req_valid[i] && req_ready[i];
// a response transfers in a cycle where rsp_valid && rsp_ready. Senders hold
// valid and payload stable until the transfer; ready never depends on
// anything but state, the valid vector and the round-robin pointer.
module barrel_shift_sched
   import barrel_shift_sched_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int NUM_REQ = DEFAULT_NUM_REQ,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
   input  logic [NUM_REQ-1:0]         req_left,
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
   input  logic [NUM_REQ-1:0]         req_rotate,
`endif
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_data,
   output logic [ID_W-1:0]            rsp_id,
   output logic [WIDTH-1:0]           sh_data_in,
   output logic [SHAMT_W-1:0]         sh_shift_amount,
   output logic                       sh_shift_left,
   input  logic [WIDTH-1:0]           sh_data_out,
   output logic [1:0]                 dbg_state
);

   state_t               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [WIDTH-1:0]     sh_data_q, sh_data_d;
   logic [SHAMT_W-1:0]   sh_shamt_q, sh_shamt_d;
   logic                 sh_left_q, sh_left_d;
   logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
   logic                 rsp_valid_q, rsp_valid_d;
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
   logic                 rot_q, rot_d;
   logic [WIDTH-1:0]     tmp_q, tmp_d;
   logic                 sel_rot;
`endif

   logic [NUM_REQ-1:0]   grant;
   logic [ID_W-1:0]      grant_idx;
   logic [WIDTH-1:0]     sel_data;
   logic [SHAMT_W-1:0]   sel_shamt;
   logic                 sel_left;
   logic                 accept;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Ready only while idle and out of reset, so a reset drops it at once.
   assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;
   assign accept    = |req_ready;

   // One-hot payload mux for the granted requester.
   always_comb begin
      sel_data  = '0;
      sel_shamt = '0;
      sel_left  = 1'b0;
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
      sel_rot   = 1'b0;
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_data  = sel_data  | req_data[i*WIDTH +: WIDTH];
            sel_shamt = sel_shamt | req_shamt[i*SHAMT_W +: SHAMT_W];
            sel_left  = sel_left  | req_left[i];
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
            sel_rot   = sel_rot   | req_rotate[i];
`endif
         end
      end
   end

   // Next-state and datapath updates; every register holds unless its state acts.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      sh_data_d   = sh_data_q;
      sh_shamt_d  = sh_shamt_q;
      sh_left_d   = sh_left_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = rsp_valid_q;
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
      rot_d       = rot_q;
      tmp_d       = tmp_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               sh_data_d  = sel_data;
               sh_shamt_d = sel_shamt;
               sh_left_d  = sel_left;
               id_d       = grant_idx;
               rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
               rot_d      = sel_rot;
`endif
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
            if (rot_q && sh_shamt_q != '0) begin
               // Second pass brings back the bits the first pass shifted out.
               tmp_d      = sh_data_out;
               sh_shamt_d = SHAMT_W'(WIDTH - int'(sh_shamt_q));
               sh_left_d  = ~sh_left_q;
               state_d    = SHIFT2;
            end else begin
               rsp_data_d  = sh_data_out;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
`else
            rsp_data_d  = sh_data_out;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
`endif
         end
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
         SHIFT2: begin
            rsp_data_d  = tmp_q | sh_data_out;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
`endif
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         sh_data_q   <= '0;
         sh_shamt_q  <= '0;
         sh_left_q   <= 1'b0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
         rot_q       <= 1'b0;
         tmp_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         sh_data_q   <= sh_data_d;
         sh_shamt_q  <= sh_shamt_d;
         sh_left_q   <= sh_left_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
         rot_q       <= rot_d;
         tmp_q       <= tmp_d;
`endif
      end
   end

   assign rsp_valid       = rsp_valid_q;
   assign rsp_data        = rsp_data_q;
   assign rsp_id          = id_q;
   assign sh_data_in      = sh_data_q;
   assign sh_shift_amount = sh_shamt_q;
   assign sh_shift_left   = sh_left_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_barrel_shift_sched.sv
// Testbench for barrel_shift_sched with a behavioural shared shifter.
// Optional feature macro: BARREL_SHIFT_SCHED_ROTATE_EN enables rotate tests.
module tb_barrel_shift_sched;
   import barrel_shift_sched_pkg::*;

   localparam int WIDTH   = 8;
   localparam int NUM_REQ = 4;
   localparam int SHAMT_W = 3;
   localparam int ID_W    = 2;
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic                       clk;
   logic                       rst_n;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*WIDTH-1:0]   req_data;
   logic [NUM_REQ*SHAMT_W-1:0] req_shamt;
   logic [NUM_REQ-1:0]         req_left;
   logic [NUM_REQ-1:0]         req_rotate;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [WIDTH-1:0]           rsp_data;
   logic [ID_W-1:0]            rsp_id;
   logic [WIDTH-1:0]           sh_data_in;
   logic [SHAMT_W-1:0]         sh_shift_amount;
   logic                       sh_shift_left;
   logic [WIDTH-1:0]           sh_data_out;
   logic [1:0]                 dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef logic [ID_W+WIDTH-1:0] exp_t;
   exp_t exp_q[$];

   barrel_shift_sched #(
      .WIDTH   (WIDTH),
      .NUM_REQ (NUM_REQ),
      .SHAMT_W (SHAMT_W),
      .ID_W    (ID_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_data        (req_data),
      .req_shamt       (req_shamt),
      .req_left        (req_left),
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
      .req_rotate      (req_rotate),
`endif
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .rsp_id          (rsp_id),
      .sh_data_in      (sh_data_in),
      .sh_shift_amount (sh_shift_amount),
      .sh_shift_left   (sh_shift_left),
      .sh_data_out     (sh_data_out),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External shared shifter: logical, zero fill.
   always_comb begin
      if (sh_shift_left) sh_data_out = sh_data_in << sh_shift_amount;
      else               sh_data_out = sh_data_in >> sh_shift_amount;
   end

   // Bit-level reference: shift or rotate by k.
   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int k,
                                               input bit left, input bit rot);
      logic [WIDTH-1:0] r;
      int src;
      r = '0;
      for (int j = 0; j < WIDTH; j++) begin
         src = left ? j - k : j + k;
         if (rot) src = (src + WIDTH) % WIDTH;
         if (src >= 0 && src < WIDTH) r[j] = d[src];
      end
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               exp_q.push_back({ID_W'(i), model(req_data[i*WIDTH +: WIDTH],
                                 int'(req_shamt[i*SHAMT_W +: SHAMT_W]), req_left[i],
                                 ROT_EN && req_rotate[i])});
            end
         end
         if (rsp_valid && rsp_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL scoreboard_unexpected: got id=%0d data=%h, required no response",
                        rsp_id, rsp_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if ({rsp_id, rsp_data} !== e) begin
                  n_fail++;
                  $display("FAIL scoreboard_rsp: got id=%0d data=%h, required id=%0d data=%h",
                           rsp_id, rsp_data, e[ID_W+WIDTH-1:WIDTH], e[WIDTH-1:0]);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_req(input int i, input logic [WIDTH-1:0] d, input int k,
                            input bit left, input bit rot);
      @(posedge clk); #1;
      req_data[i*WIDTH +: WIDTH]       = d;
      req_shamt[i*SHAMT_W +: SHAMT_W] = SHAMT_W'(k);
      req_left[i]                     = left;
      req_rotate[i]                   = rot;
      req_valid[i]                    = 1'b1;
   endtask

   task automatic rand_payload(input int i);
      req_data[i*WIDTH +: WIDTH]       = WIDTH'($urandom_range(0, 255));
      req_shamt[i*SHAMT_W +: SHAMT_W] = SHAMT_W'($urandom_range(0, WIDTH-1));
      req_left[i]                     = 1'($urandom_range(0, 1));
      req_rotate[i]                   = ROT_EN ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   task automatic wait_accept(input int i, output int c, output bit ok);
      ok = 1'b0;
      c  = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (req_valid[i] && req_ready[i]) begin
            ok = 1'b1;
            c  = cyc;
            break;
         end
      end
   endtask

   task automatic wait_any(output int idx, output int c, output bit ok);
      ok  = 1'b0;
      idx = -1;
      c   = 0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               ok  = 1'b1;
               idx = i;
               c   = cyc;
            end
         end
      end
   endtask

   task automatic wait_rsp(output int c, output bit ok);
      ok = 1'b0;
      c  = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok = 1'b1;
            c  = cyc;
            break;
         end
      end
   endtask

   task automatic drain();
      int n;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !rsp_valid && dbg_state == 2'(IDLE)) break;
      end
      n_checks++;
      if (exp_q.size() != 0 || n >= 200) begin
         n_fail++;
         $display("FAIL drain: pending=%0d, required 0", exp_q.size());
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n      = 1'b0;
      rsp_ready  = 1'b1;
      req_valid  = '1;
      req_data   = {NUM_REQ{8'hDB}};
      req_shamt  = '0;
      req_left   = '0;
      req_rotate = '0;
      #2;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_data, rsp_id} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ready=%b valid=%b data=%h id=%0d, required all 0",
                  req_ready, rsp_valid, rsp_data, rsp_id);
      end
      n_checks++;
      if ({sh_data_in, sh_shift_amount, sh_shift_left, dbg_state} !== '0) begin
         n_fail++;
         $display("FAIL reset_shifter_regs: got d=%h k=%0d l=%b st=%0d, required all 0",
                  sh_data_in, sh_shift_amount, sh_shift_left, dbg_state);
      end
      req_valid = '0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single(input int i, input logic [WIDTH-1:0] d, input int k,
                              input bit left, input bit rot, input logic [WIDTH-1:0] exp_d);
      int ca, cr, lat;
      bit ok;
      lat = (rot && ROT_EN && k != 0) ? 3 : 2;
      drive_req(i, d, k, left, rot);
      wait_accept(i, ca, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_accept: req%0d not accepted within budget, required accept", i);
      end
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      n_checks++;
      if ({sh_data_in, sh_shift_amount, sh_shift_left} !== {d, SHAMT_W'(k), left}) begin
         n_fail++;
         $display("FAIL single_sh_regs: got d=%h k=%0d l=%b, required d=%h k=%0d l=%b",
                  sh_data_in, sh_shift_amount, sh_shift_left, d, k, left);
      end
      wait_rsp(cr, ok);
      n_checks++;
      if (!ok || cr - ca != lat) begin
         n_fail++;
         $display("FAIL single_latency: got %0d cycles (seen=%b), required %0d", cr - ca, ok, lat);
      end
      n_checks++;
      if ({rsp_id, rsp_data} !== {ID_W'(i), exp_d}) begin
         n_fail++;
         $display("FAIL single_rsp: got id=%0d data=%h, required id=%0d data=%h",
                  rsp_id, rsp_data, i, exp_d);
      end
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_rsp_drop: got rsp_valid=%b, required 0", rsp_valid);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      int idx, c, prev;
      bit ok;
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) rand_payload(i);
      req_valid = '1;
      rst_n     = 1'b1;
      prev      = 0;
      for (int k = 0; k < 5; k++) begin
         wait_any(idx, c, ok);
         n_checks++;
         if (!ok || idx != k % NUM_REQ) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got grant=%0d, required %0d", k, idx, k % NUM_REQ);
         end
         if (k > 0) begin
            n_checks++;
            if (c - prev != 3) begin
               n_fail++;
               $display("FAIL rr_spacing[%0d]: got %0d cycles, required 3", k, c - prev);
            end
         end
         prev = c;
         @(posedge clk); #1;
         if (ok) rand_payload(idx);
      end
      req_valid = '0;
      drain();
   endtask

   task automatic test_backpressure();
      int ca, cr, idx, c;
      bit ok;
      // rr_ptr is 1 here: the round-robin test last accepted requester 0.
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_data[1*WIDTH +: WIDTH]       = 8'hA5;
      req_shamt[1*SHAMT_W +: SHAMT_W] = 3'd2;
      req_left[1]                     = 1'b0;
      req_rotate[1]                   = 1'b0;
      rand_payload(0);
      rand_payload(3);
      req_valid = 4'b1011;
      wait_accept(1, ca, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bp_accept: req1 not accepted, required accept");
      end
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_rsp(cr, ok);
      for (int n = 0; n < 5; n++) begin
         n_checks++;
         if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 2'd1, 8'h29, 4'b0000}) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h rdy=%b, required v=1 id=1 d=29 rdy=0000",
                     n, rsp_valid, rsp_id, rsp_data, req_ready);
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_any(idx, c, ok);
      n_checks++;
      if (!ok || idx != 3) begin
         n_fail++;
         $display("FAIL bp_next_grant: got %0d, required 3", idx);
      end
      @(posedge clk); #1;
      req_valid[3] = 1'b0;
      wait_any(idx, c, ok);
      n_checks++;
      if (!ok || idx != 0) begin
         n_fail++;
         $display("FAIL bp_wrap_grant: got %0d, required 0", idx);
      end
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      drain();
   endtask

   task automatic test_reset_mid();
      int ca, idx, c;
      bit ok;
      drive_req(1, 8'h3C, 1, 1'b1, 1'b0);
      wait_accept(1, ca, ok);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dbg_state !== 2'(SHIFT)) begin
         n_fail++;
         $display("FAIL midrst_in_shift: got state=%0d, required %0d", dbg_state, SHIFT);
      end
      #1;
      rst_n = 1'b0;
      rand_payload(0);
      rand_payload(1);
      rand_payload(3);
      req_valid = 4'b1011;
      #1;
      n_checks++;
      if ({rsp_valid, req_ready, dbg_state} !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got v=%b rdy=%b st=%0d, required 0/0000/0",
                  rsp_valid, req_ready, dbg_state);
      end
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_any(idx, c, ok);
         n_checks++;
         if (!ok || idx != ((k == 2) ? 3 : k)) begin
            n_fail++;
            $display("FAIL midrst_grant[%0d]: got %0d, required %0d", k, idx, (k == 2) ? 3 : k);
         end
         @(posedge clk); #1;
         if (ok) req_valid[idx] = 1'b0;
      end
      drain();
   endtask

   task automatic test_random();
      logic [NUM_REQ-1:0] hs;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk); #1;
         req_valid = req_valid & ~hs;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               rand_payload(i);
               req_valid[i] = 1'b1;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      drain();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single(0, 8'hDB, 1, 1'b1, 1'b0, 8'hB6);
      test_single(2, 8'hDB, 1, 1'b0, 1'b0, 8'h6D);
      test_single(2, 8'hDB, 0, 1'b0, 1'b0, 8'hDB);
      test_single(3, 8'hDB, 7, 1'b1, 1'b0, 8'h80);
      test_single(1, 8'hDB, 7, 1'b0, 1'b0, 8'h01);
      test_round_robin();
      test_backpressure();
      test_reset_mid();
`ifdef BARREL_SHIFT_SCHED_ROTATE_EN
      test_single(0, 8'hDB, 3, 1'b1, 1'b1, 8'hDE);
      test_single(1, 8'hDB, 3, 1'b0, 1'b1, 8'h7B);
      test_single(2, 8'hDB, 0, 1'b1, 1'b1, 8'hDB);
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
